// File: rtl/cpu_axi_bridge_pkg.sv
// Shared constants, FSM encodings and size helper for the CPU-to-AXI3 bridge.
package cpu_axi_bridge_pkg;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_SINGLE = 4'd0;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_WAIT = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  // CPU size codes 0/1/2 map directly onto AXI byte/half/word sizes.
  function automatic logic [2:0] axi_size(input logic [1:0] cpu_size);
    return {1'b0, cpu_size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_write.sv
// Single-beat AXI3 write engine: issues AW and W together, completes each
// handshake independently, then waits for the B response.
module axi_write_ctrl
  import cpu_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_accept,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awsize,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic        o_b_done
);

  wr_state_e   r_state;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic        r_awvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wvalid;
  logic        r_bready;
  logic        w_aw_done;
  logic        w_w_done;

  // A channel counts as done once its valid has dropped or it handshakes now.
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= W_IDLE;
      r_awaddr  <= 32'd0;
      r_awsize  <= 3'd0;
      r_awvalid <= 1'b0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (i_accept) begin
            r_awaddr  <= i_addr;
            r_awsize  <= i_size;
            r_wdata   <= i_wdata;
            r_wstrb   <= i_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= W_REQ;
          end
        end
        W_REQ: begin
          if (i_awready) r_awvalid <= 1'b0;
          if (i_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= W_B;
          end
        end
        W_B: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= W_IDLE;
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_state   <= W_IDLE;
        end
      endcase
    end
  end

  assign o_awaddr  = r_awaddr;
  assign o_awsize  = r_awsize;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_b_done  = (r_state == W_B) && i_bvalid;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Converts the core's SRAM-like instruction and data ports into one AXI3
// master with single-beat transfers; reads share one AR/R engine.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic [31:0]     inst_addr,
  output logic [31:0]     inst_rdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [3:0]      data_wstrb,
  input  logic [31:0]     data_addr,
  input  logic [2:0]      data_size,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  rd_state_e       r_rstate;
  logic [31:0]     r_araddr;
  logic [2:0]      r_arsize;
  logic [ID_W-1:0] r_arid;
  logic            r_arvalid;
  logic            r_rready;
  logic [31:0]     r_inst_rdata;
  logic [31:0]     r_data_rdata;
  logic            r_inst_data_ok;
  logic            r_data_data_ok;
  logic            r_inst_busy;
  logic            r_data_busy;

  logic            w_inst_idle;
  logic            w_data_idle;
  logic            w_rd_free;
  logic            w_data_rd_acc;
  logic            w_data_wr_acc;
  logic            w_inst_acc;
  logic            w_r_hs;
  logic            w_rid_data;
  logic            w_b_done;
  logic            w_unused;

  // Responses are always completed as OKAY and a single beat is always last.
  assign w_unused = ^{rresp, rlast, bresp, bid, data_size[2]};

  // A port frees up in the very cycle its data_ok is presented to the core.
  assign w_inst_idle   = !r_inst_busy || r_inst_data_ok;
  assign w_data_idle   = !r_data_busy || r_data_data_ok;
  assign w_rd_free     = resetn && (r_rstate == R_IDLE);
  assign w_data_rd_acc = w_rd_free && data_req && !data_wr && w_data_idle;
  assign w_data_wr_acc = resetn && data_req && data_wr && w_data_idle;
  assign w_inst_acc    = w_rd_free && inst_req && w_inst_idle && !w_data_rd_acc;
  assign w_r_hs        = (r_rstate == R_WAIT) && rvalid;
  assign w_rid_data    = (rid == ID_W'(DATA_ID));

  assign inst_addr_ok  = w_inst_acc;
  assign data_addr_ok  = w_data_rd_acc || w_data_wr_acc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rstate     <= R_IDLE;
      r_araddr     <= 32'd0;
      r_arsize     <= 3'd0;
      r_arid       <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_data_rd_acc) begin
            r_araddr  <= data_addr;
            r_arsize  <= axi_size(data_size[1:0]);
            r_arid    <= ID_W'(DATA_ID);
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end else if (w_inst_acc) begin
            r_araddr  <= inst_addr;
            r_arsize  <= SIZE_WORD;
            r_arid    <= ID_W'(INST_ID);
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_rstate <= R_IDLE;
            if (w_rid_data) begin
              r_data_rdata <= rdata;
            end else begin
              r_inst_rdata <= rdata;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
    end else begin
      r_inst_data_ok <= w_r_hs && !w_rid_data;
      r_data_data_ok <= (w_r_hs && w_rid_data) || w_b_done;
    end
  end

  // Busy spans addr_ok..data_ok; a same-cycle re-accept keeps it set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_busy <= 1'b0;
      r_data_busy <= 1'b0;
    end else begin
      if (w_inst_acc) begin
        r_inst_busy <= 1'b1;
      end else if (r_inst_data_ok) begin
        r_inst_busy <= 1'b0;
      end
      if (data_addr_ok) begin
        r_data_busy <= 1'b1;
      end else if (r_data_data_ok) begin
        r_data_busy <= 1'b0;
      end
    end
  end

  axi_write_ctrl u_write (
    .clk       (clk),
    .resetn    (resetn),
    .i_accept  (w_data_wr_acc),
    .i_addr    (data_addr),
    .i_size    (axi_size(data_size[1:0])),
    .i_wdata   (data_wdata),
    .i_wstrb   (data_wstrb),
    .o_awaddr  (awaddr),
    .o_awsize  (awsize),
    .o_awvalid (awvalid),
    .i_awready (awready),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .o_wvalid  (wvalid),
    .i_wready  (wready),
    .i_bvalid  (bvalid),
    .o_bready  (bready),
    .o_b_done  (w_b_done)
  );

  assign inst_rdata   = r_inst_rdata;
  assign inst_data_ok = r_inst_data_ok;
  assign data_rdata   = r_data_rdata;
  assign data_data_ok = r_data_data_ok;
  assign arid         = r_arid;
  assign araddr       = r_araddr;
  assign arsize       = r_arsize;
  assign arvalid      = r_arvalid;
  assign rready       = r_rready;
  assign arlen        = LEN_SINGLE;
  assign awlen        = LEN_SINGLE;
  assign arburst      = BURST_INCR;
  assign awburst      = BURST_INCR;
  assign awid         = ID_W'(DATA_ID);
  assign wlast        = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: a transaction-level model of both ports
// is checked every cycle, plus hand-computed expectations per scenario.
module tb_cpu_axi_bridge;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [3:0]  data_wstrb = 4'd0;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
  logic [2:0]  data_size = 3'd0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, arlen, awlen, rid = 4'd0, bid = 4'd0;
  logic [31:0] araddr, awaddr, wdata, rdata = 32'd0;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp = 2'd0, bresp = 2'd0;
  logic        arvalid, arready = 1'b0, rlast = 1'b1, rvalid = 1'b0, rready;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;

  cpu_axi_bridge #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  int cnt_iaok = 0, cnt_daok = 0, cnt_iok = 0, cnt_dok = 0, cnt_arv = 0, cnt_awv = 0, cnt_wv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: what the bridge must be doing, in transaction terms.
  bit          m_on = 1'b0;
  bit          m_inst_busy, m_data_busy, m_inst_ok, m_data_ok;
  int          rd_ph, wr_ph;      // 0 none, 1 address phase, 2 response phase
  bit          aw_pend, w_pend;
  logic [31:0] m_araddr, m_inst_rdata, m_data_rdata, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [3:0]  m_arid, m_wstrb;
  bit          e_drd, e_dwr, e_inst, n_iok, n_dok;

  always @(negedge clk) begin
    e_drd  = m_on && resetn && rd_ph == 0 && data_req && !data_wr && (!m_data_busy || m_data_ok);
    e_dwr  = m_on && resetn && data_req && data_wr && (!m_data_busy || m_data_ok);
    e_inst = m_on && resetn && rd_ph == 0 && inst_req && (!m_inst_busy || m_inst_ok) && !e_drd;
    if (m_on) begin
      chk("inst_addr_ok", inst_addr_ok, e_inst);
      chk("data_addr_ok", data_addr_ok, e_drd || e_dwr);
      chk("inst_data_ok", inst_data_ok, m_inst_ok);
      chk("data_data_ok", data_data_ok, m_data_ok);
      chk("inst_rdata", inst_rdata, m_inst_rdata);
      chk("data_rdata", data_rdata, m_data_rdata);
      chk("arvalid", arvalid, rd_ph == 1);
      chk("araddr", araddr, m_araddr);
      chk("arsize", arsize, m_arsize);
      chk("arid", arid, m_arid);
      chk("rready", rready, rd_ph == 2);
      chk("awvalid", awvalid, aw_pend);
      chk("wvalid", wvalid, w_pend);
      chk("awaddr", awaddr, m_awaddr);
      chk("awsize", awsize, m_awsize);
      chk("wdata", wdata, m_wdata);
      chk("wstrb", wstrb, m_wstrb);
      chk("bready", bready, wr_ph == 2);
      chk("awid", awid, ID_DATA);
      chk("wlast", wlast, 1'b1);
      chk("axlen", {arlen, awlen}, 8'h00);
      chk("axburst", {arburst, awburst}, 4'b0101);
      cnt_iaok += int'(inst_addr_ok === 1'b1);
      cnt_daok += int'(data_addr_ok === 1'b1);
      cnt_iok  += int'(inst_data_ok === 1'b1);
      cnt_dok  += int'(data_data_ok === 1'b1);
      cnt_arv  += int'(arvalid === 1'b1);
      cnt_awv  += int'(awvalid === 1'b1);
      cnt_wv   += int'(wvalid === 1'b1);
    end
    // Advance the model to the state after the coming rising edge.
    if (!resetn) begin
      m_on = 1'b1; m_inst_busy = 1'b0; m_data_busy = 1'b0; m_inst_ok = 1'b0; m_data_ok = 1'b0;
      rd_ph = 0; wr_ph = 0; aw_pend = 1'b0; w_pend = 1'b0;
      m_araddr = 32'd0; m_inst_rdata = 32'd0; m_data_rdata = 32'd0; m_awaddr = 32'd0;
      m_wdata = 32'd0; m_arsize = 3'd0; m_awsize = 3'd0; m_arid = 4'd0; m_wstrb = 4'd0;
    end else if (m_on) begin
      n_iok = 1'b0; n_dok = 1'b0;
      if (e_inst) m_inst_busy = 1'b1; else if (m_inst_ok) m_inst_busy = 1'b0;
      if (e_drd || e_dwr) m_data_busy = 1'b1; else if (m_data_ok) m_data_busy = 1'b0;
      if (rd_ph == 0) begin
        if (e_drd) begin
          rd_ph = 1; m_araddr = data_addr; m_arid = ID_DATA;
          m_arsize = (data_size[1:0] == 2'd0) ? 3'd0 : (data_size[1:0] == 2'd1) ? 3'd1 : 3'd2;
        end else if (e_inst) begin
          rd_ph = 1; m_araddr = inst_addr; m_arid = ID_INST; m_arsize = 3'd2;
        end
      end else if (rd_ph == 1) begin
        if (arready) rd_ph = 2;
      end else if (rvalid) begin
        rd_ph = 0;
        if (rid == ID_DATA) begin n_dok = 1'b1; m_data_rdata = rdata; end
        else begin n_iok = 1'b1; m_inst_rdata = rdata; end
      end
      if (wr_ph == 0) begin
        if (e_dwr) begin
          wr_ph = 1; aw_pend = 1'b1; w_pend = 1'b1; m_awaddr = data_addr; m_wdata = data_wdata;
          m_wstrb = data_wstrb; m_awsize = (data_size[1:0] == 2'd0) ? 3'd0 : (data_size[1:0] == 2'd1) ? 3'd1 : 3'd2;
        end
      end else if (wr_ph == 1) begin
        if (awready) aw_pend = 1'b0;
        if (wready) w_pend = 1'b0;
        if (!aw_pend && !w_pend) wr_ph = 2;
      end else if (bvalid) begin
        wr_ph = 0; n_dok = 1'b1;
      end
      m_inst_ok = n_iok; m_data_ok = n_dok;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ar_handshake(input int wait_cyc);
    int k = 0;
    while (arvalid !== 1'b1 && k < 50) begin tick(); k++; end
    chk("ar_wait_arvalid", arvalid, 1'b1);
    repeat (wait_cyc) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input int dly);
    int k = 0;
    repeat (dly) tick();
    rvalid = 1'b1; rid = id; rdata = d;
    while (rready !== 1'b1 && k < 50) begin tick(); k++; end
    chk("r_wait_rready", rready, 1'b1);
    tick();
    rvalid = 1'b0;
  endtask

  task automatic aw_w(input int aw_wait, input int w_wait);
    int k = 0;
    bit aw_d = 1'b0, w_d = 1'b0;
    while (awvalid !== 1'b1 && k < 50) begin tick(); k++; end
    chk("aw_wait_awvalid", awvalid, 1'b1);
    for (int c = 0; c < 50 && !(aw_d && w_d); c++) begin
      awready = !aw_d && c >= aw_wait;
      wready  = !w_d && c >= w_wait;
      tick();
      if (awready) aw_d = 1'b1;
      if (wready) w_d = 1'b1;
    end
    awready = 1'b0; wready = 1'b0;
  endtask

  task automatic b_resp(input int dly);
    int k = 0;
    repeat (dly) tick();
    bvalid = 1'b1; bid = ID_DATA; bresp = 2'b10;
    while (bready !== 1'b1 && k < 50) begin tick(); k++; end
    chk("b_wait_bready", bready, 1'b1);
    tick();
    bvalid = 1'b0; bresp = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0, c1, c2, c3;

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Instruction fetch with immediate arready and late R beat.
    c0 = cnt_iaok; c1 = cnt_arv; c2 = cnt_iok;
    inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
    chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    tick(); inst_req = 1'b0;
    ar_handshake(0);
    r_beat(ID_INST, 32'h3C1D0001, 2);
    chk("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D0001);
    tick();
    chk("t1_addr_ok_count", cnt_iaok - c0, 1);
    chk("t1_arvalid_cycles", cnt_arv - c1, 1);
    chk("t1_data_ok_count", cnt_iok - c2, 1);

    // Simultaneous inst and data read: data wins.
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 3'd2; data_addr = 32'h80001000; #1;
    chk("t2_data_addr_ok", data_addr_ok, 1'b1);
    chk("t2_inst_blocked", inst_addr_ok, 1'b0);
    tick(); data_req = 1'b0;
    chk("t2_arid", arid, 32'd1);
    chk("t2_araddr", araddr, 32'h80001000);
    c0 = cnt_iaok;
    ar_handshake(0);
    r_beat(ID_DATA, 32'h12345678, 1);
    #1;
    chk("t2_data_ok", data_data_ok, 1'b1);
    chk("t2_inst_accept_now", inst_addr_ok, 1'b1);
    chk("t2_inst_waited", cnt_iaok - c0, 0);
    tick(); inst_req = 1'b0;
    chk("t2_inst_arid", arid, 32'd0);
    ar_handshake(0);
    r_beat(ID_INST, 32'h24210001, 0);
    chk("t2_inst_rdata", inst_rdata, 32'h24210001);
    tick();

    // Byte store, AW accepted two cycles before W.
    data_req = 1'b1; data_wr = 1'b1; data_size = 3'd0; data_wstrb = 4'b0010;
    data_addr = 32'h80000005; data_wdata = 32'h0000AB00; #1;
    chk("t3_data_addr_ok", data_addr_ok, 1'b1);
    tick(); data_req = 1'b0;
    chk("t3_awsize", awsize, 32'd0);
    c0 = cnt_awv; c1 = cnt_wv; c2 = cnt_dok;
    aw_w(0, 2);
    b_resp(1);
    chk("t3_data_ok", data_data_ok, 1'b1);
    tick();
    chk("t3_awvalid_cycles", cnt_awv - c0, 1);
    chk("t3_wvalid_cycles", cnt_wv - c1, 3);
    chk("t3_data_ok_count", cnt_dok - c2, 1);

    // Store immediately followed by a load held until the store completes.
    data_req = 1'b1; data_wr = 1'b1; data_size = 3'd2; data_wstrb = 4'hF;
    data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF; #1;
    tick();
    data_wr = 1'b0;
    c0 = cnt_daok;
    aw_w(0, 0);
    b_resp(0);
    #1;
    chk("t4_store_ok", data_data_ok, 1'b1);
    chk("t4_load_accept", data_addr_ok, 1'b1);
    chk("t4_load_waited", cnt_daok - c0, 0);
    tick(); data_req = 1'b0;
    chk("t4_araddr", araddr, 32'h80000010);
    ar_handshake(0);
    r_beat(ID_DATA, 32'hCAFEF00D, 2);
    chk("t4_data_rdata", data_rdata, 32'hCAFEF00D);
    tick();

    // arready held low for 10 cycles with a competing inst request.
    data_req = 1'b1; data_wr = 1'b0; data_size = 3'd1; data_addr = 32'h80002002; #1;
    tick(); data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    chk("t5_arsize", arsize, 32'd1);
    c0 = cnt_arv; c1 = cnt_iaok; c2 = cnt_daok; c3 = cnt_iok + cnt_dok;
    ar_handshake(10);
    inst_req = 1'b0;
    chk("t5_arvalid_cycles", cnt_arv - c0, 11);
    chk("t5_no_inst_accept", cnt_iaok - c1, 0);
    chk("t5_no_data_accept", cnt_daok - c2, 0);
    chk("t5_no_data_ok", cnt_iok + cnt_dok - c3, 0);
    r_beat(ID_DATA, 32'h0000BEEF, 0);
    chk("t5_data_rdata", data_rdata, 32'h0000BEEF);
    tick();

    // Reset while waiting for R.
    inst_req = 1'b1; inst_addr = 32'hBFC00200; #1;
    tick(); inst_req = 1'b0;
    ar_handshake(0);
    chk("t6_rready_before", rready, 1'b1);
    resetn = 1'b0; rvalid = 1'b1; rid = ID_INST; rdata = 32'h55555555;
    tick();
    resetn = 1'b1; rvalid = 1'b0;
    c0 = cnt_iok + cnt_dok;
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_rready", rready, 1'b0);
    chk("t6_inst_data_ok", inst_data_ok, 1'b0);
    chk("t6_inst_rdata", inst_rdata, 32'd0);
    repeat (2) tick();
    chk("t6_no_data_ok", cnt_iok + cnt_dok - c0, 0);
    inst_req = 1'b1; inst_addr = 32'hBFC00300; #1;
    chk("t6_fresh_accept", inst_addr_ok, 1'b1);
    tick(); inst_req = 1'b0;
    chk("t6_araddr", araddr, 32'hBFC00300);
    ar_handshake(0);
    r_beat(ID_INST, 32'h8FBF0010, 0);
    chk("t6_inst_rdata_new", inst_rdata, 32'h8FBF0010);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core and converts its two SRAM-like ports into one AXI3 master with single-beat transfers only.
  - Instruction port: read-only.
  - Data port: read and write.
- Each port has at most one transaction in flight, so responses to the core are strictly in order per port.

Parameters:
ID_W, 4, AXI ID width
INST_ID, 0, arid used for instruction fetches
DATA_ID, 1, arid/awid used for data accesses

Ports:
clk  in  1  clock
resetn  in  1  reset
inst_req  in  1  instruction request valid
inst_addr  in  32  instruction physical address
inst_rdata  out  32  fetched word
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
data_req  in  1  data request valid
data_wr  in  1  1=write, 0=read
data_wstrb  in  4  byte strobes
data_addr  in  32  data physical address
data_size  in  3  0=byte, 1=half, 2=word
data_wdata  in  32  write data
data_rdata  out  32  load data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  one-cycle pulse, read data valid or write done
arid/araddr/arsize/arvalid  out  ID_W/32/3/1  AR channel; arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  R channel; rready  out  1
awid/awaddr/awsize/awvalid  out  ID_W/32/3/1  AW channel; awready  in  1
wdata/wstrb/wlast/wvalid  out  32/4/1/1  W channel; wready  in  1
bid/bresp/bvalid  in  ID_W/2/1  B channel; bready  out  1
arlen/awlen  out  4  constant 0
arburst/awburst  out  2  constant 01

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset:
  - Both FSMs go to IDLE.
  - All valid/ready outputs, addr_ok and data_ok are 0.
  - Registered address/data/rdata outputs are 0.
- Read FSM: R_IDLE -> R_AR -> R_WAIT -> R_IDLE.
  - Acceptance in R_IDLE:
    - Data read (data_req && !data_wr) is accepted if the data port is idle.
    - Otherwise inst_req is accepted if the inst port is idle.
    - Data has priority: when both are present, inst_addr_ok=0 that cycle.
  - addr_ok is combinational and asserted in the acceptance cycle; address, size and ID are latched.
  - arsize = {1'b0,data_size[1:0]}; instruction reads use 3'b010.
  - R_AR drives arvalid and holds it until arready; moves to R_WAIT on handshake.
  - R_WAIT drives rready=1. On rvalid it latches rdata into the port selected by rid and returns to R_IDLE.
  - The matching *_data_ok pulses the cycle after the R handshake, together with registered *_rdata.
  - Earliest next acceptance is in the same cycle data_ok is seen.
- Write FSM: W_IDLE -> W_REQ -> W_B -> W_IDLE.
  - Accepts data_req && data_wr when the data port is idle; data_addr_ok=1 and addr/size/wdata/wstrb are latched.
  - W_REQ drives awvalid and wvalid together and tracks each handshake independently; either may complete first or both in the same cycle.
  - Moves to W_B when both are done. wlast=1.
  - W_B drives bready=1; on bvalid, data_data_ok pulses the next cycle.
- Data port busy flag: set on data_addr_ok, cleared on data_data_ok. A new data request is never accepted while busy, so a read is never reordered around a write.
- Inst port busy flag: same rule with inst_addr_ok/inst_data_ok.
- Only one read is outstanding at a time; an instruction fetch waits behind a data read and vice versa.
- Response codes are ignored: rresp/bresp errors are completed as OKAY.
- Unexpected rid/bid values are never produced by a conforming slave and are not checked.
- Reset asserted mid-transaction: FSMs abandon the transaction immediately and no data_ok is generated.

Decomposition:
- Shared package holds:
  - AXI size/burst constants: SIZE_WORD=3'b010, BURST_INCR=2'b01.
  - The R_* and W_* state encodings.
- One natural sub-module, axi_write_ctrl, containing the write FSM with independent AW/W completion tracking.
- The read FSM and arbitration stay in the top.

Test Plan:
- Inst read 0xBFC00000 with arready=1 and rvalid 3 cycles later (rdata=0x3C1D0001) -> inst_addr_ok in cycle 0, arvalid one cycle, inst_data_ok one cycle with inst_rdata=0x3C1D0001.
- inst_req and data read 0x80001000 in the same cycle -> data_addr_ok=1, inst_addr_ok=0, arid=1; inst is accepted only after data_data_ok.
- Byte store (size=0, wstrb=0010, wdata=0x0000AB00, addr 0x80000005) with awready asserted two cycles before wready -> awvalid drops after its handshake, wvalid held until wready, then bready; data_data_ok one pulse.
- Store followed by load on the same cycle data_data_ok arrives -> load addr_ok only once busy clears; AR issued after the B response; data_rdata taken from the R beat.
- Hold arready=0 for 10 cycles -> arvalid and araddr stable throughout, no data_ok, no second addr_ok on either port.
- resetn low while in R_WAIT -> next cycle arvalid=0, rready=0, no data_ok; a fresh inst_req is accepted after reset is released.
